// File: rtl/alarm_pkg.sv
// Shared definitions for the alarm scheduler: channel count, FSM encoding,
// default timing parameters and a counter-width helper.
package alarm_pkg;

    localparam int NUM_CH = 4;
    localparam int ID_W   = 2;

    localparam int DEF_SNOOZE_S   = 300;
    localparam int DEF_TIMEOUT_S  = 60;
    localparam int DEF_MAX_SNOOZE = 3;
    localparam int DEF_GAP_MS     = 100;
    localparam int DEF_BEEP_MS    = 100;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RING = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    // Bits needed to hold 0..max_val, never less than one.
    function automatic int cnt_w(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/alarm_chan.sv
// One alarm channel: trigger edge detect, pending flag, snooze countdown and
// snooze counter. The top tells it when it is granted, ringing or snoozed.
module alarm_chan
    import alarm_pkg::*;
#(
    parameter int SNOOZE_S   = DEF_SNOOZE_S,
    parameter int MAX_SNOOZE = DEF_MAX_SNOOZE
) (
    input  logic clk_01,
    input  logic rst,
    input  logic tick_1hz,
    input  logic match,
    input  logic arm,
    input  logic ring_en,
    input  logic grant,
    input  logic ringing,
    input  logic snooze_req,
    output logic pending,
    output logic snoozed
);

    localparam int TMR_W  = cnt_w(SNOOZE_S);
    localparam int SCNT_W = cnt_w(MAX_SNOOZE);

    logic              trig_q, trig_d;
    logic              pending_q, pending_d;
    logic              snoozed_q, snoozed_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic [SCNT_W-1:0] scnt_q, scnt_d;
    logic              rise;

    always_comb begin
        trig_d    = match & arm;
        rise      = trig_d & ~trig_q;
        pending_d = pending_q;
        snoozed_d = snoozed_q;
        timer_d   = timer_q;
        scnt_d    = scnt_q;

        if (grant) begin
            pending_d = 1'b0;
        end
        if (snoozed_q && tick_1hz) begin
            if (timer_q <= TMR_W'(1)) begin
                timer_d   = '0;
                snoozed_d = 1'b0;
                pending_d = 1'b1;
            end else begin
                timer_d = timer_q - TMR_W'(1);
            end
        end
        // A snooze request past the allowance is simply a dismissal.
        if (snooze_req && (scnt_q < SCNT_W'(MAX_SNOOZE))) begin
            scnt_d    = scnt_q + SCNT_W'(1);
            snoozed_d = 1'b1;
            timer_d   = TMR_W'(SNOOZE_S);
        end
        if (rise && !pending_q && !ringing && !snoozed_q) begin
            pending_d = 1'b1;
            scnt_d    = '0;
        end
        if (!ring_en) begin
            pending_d = 1'b0;
        end
        // Disarm overrides everything, including a same-cycle snooze.
        if (!arm) begin
            pending_d = 1'b0;
            snoozed_d = 1'b0;
            timer_d   = '0;
            scnt_d    = '0;
        end
    end

    always_ff @(posedge clk_01 or negedge rst) begin
        if (!rst) begin
            trig_q    <= 1'b0;
            pending_q <= 1'b0;
            snoozed_q <= 1'b0;
            timer_q   <= '0;
            scnt_q    <= '0;
        end else begin
            trig_q    <= trig_d;
            pending_q <= pending_d;
            snoozed_q <= snoozed_d;
            timer_q   <= timer_d;
            scnt_q    <= scnt_d;
        end
    end

    assign pending = pending_q;
    assign snoozed = snoozed_q;

endmodule

// File: rtl/alarm_scheduler.sv
// Four-channel alarm scheduler: fixed-priority arbiter, IDLE/RING/GAP FSM,
// button edge detection, ring timeout and beep timer.
module alarm_scheduler
    import alarm_pkg::*;
#(
    parameter int SNOOZE_S   = DEF_SNOOZE_S,
    parameter int TIMEOUT_S  = DEF_TIMEOUT_S,
    parameter int MAX_SNOOZE = DEF_MAX_SNOOZE,
    parameter int GAP_MS     = DEF_GAP_MS,
    parameter int BEEP_MS    = DEF_BEEP_MS
) (
    input  logic              clk_01,
    input  logic              rst,
    input  logic              tick_1hz,
    input  logic [NUM_CH-1:0] match,
    input  logic [NUM_CH-1:0] arm,
    input  logic              ring_en,
    input  logic              pulse_mode,
    input  logic              snooze_btn,
    input  logic              stop_btn,
    output logic              ring_active,
    output logic [ID_W-1:0]   ring_id,
    output logic [NUM_CH-1:0] led,
    output logic              buzz,
    output logic [NUM_CH-1:0] snoozed
);

    localparam int GAP_W  = cnt_w(GAP_MS);
    localparam int TMO_W  = cnt_w(TIMEOUT_S);
    localparam int BEEP_W = cnt_w(BEEP_MS);

    logic [1:0]        state_q, state_d;
    logic [ID_W-1:0]   ring_ch_q, ring_ch_d;
    logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic [BEEP_W-1:0] beep_cnt_q, beep_cnt_d;
    logic              beep_ph_q, beep_ph_d;
    logic              stop_prev_q, snz_prev_q;

    logic [NUM_CH-1:0] pending, grant, ringing, snooze_req;
    logic [ID_W-1:0]   grant_id;
    logic              stop_rise, snz_rise, timeout;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
        assign ringing[i] = (state_q == ST_RING) && (ring_ch_q == ID_W'(i));
        alarm_chan #(
            .SNOOZE_S   (SNOOZE_S),
            .MAX_SNOOZE (MAX_SNOOZE)
        ) u_chan (
            .clk_01     (clk_01),
            .rst        (rst),
            .tick_1hz   (tick_1hz),
            .match      (match[i]),
            .arm        (arm[i]),
            .ring_en    (ring_en),
            .grant      (grant[i]),
            .ringing    (ringing[i]),
            .snooze_req (snooze_req[i]),
            .pending    (pending[i]),
            .snoozed    (snoozed[i])
        );
    end

    // Descending scan so the lowest pending index wins.
    always_comb begin
        grant_id = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (pending[i]) grant_id = ID_W'(i);
        end
    end

    always_comb begin
        state_d    = state_q;
        ring_ch_d  = ring_ch_q;
        gap_cnt_d  = gap_cnt_q;
        tmo_d      = tmo_q;
        beep_cnt_d = beep_cnt_q;
        beep_ph_d  = beep_ph_q;
        grant      = '0;
        snooze_req = '0;
        stop_rise  = stop_btn & ~stop_prev_q;
        snz_rise   = snooze_btn & ~snz_prev_q;
        timeout    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (ring_en && (|pending)) begin
                    state_d         = ST_RING;
                    ring_ch_d       = grant_id;
                    grant[grant_id] = 1'b1;
                    tmo_d           = '0;
                    beep_cnt_d      = '0;
                    beep_ph_d       = 1'b1;
                end
            end
            ST_RING: begin
                if (tick_1hz && (tmo_q != TMO_W'(TIMEOUT_S))) tmo_d = tmo_q + TMO_W'(1);
                timeout = tick_1hz && (tmo_q >= TMO_W'(TIMEOUT_S - 1));
                if (beep_cnt_q >= BEEP_W'(BEEP_MS - 1)) begin
                    beep_cnt_d = '0;
                    beep_ph_d  = ~beep_ph_q;
                end else begin
                    beep_cnt_d = beep_cnt_q + BEEP_W'(1);
                end
                // Stop wins over a simultaneous snooze or timeout.
                if (!arm[ring_ch_q] || stop_rise) begin
                    state_d = ST_GAP;
                end else if (snz_rise || timeout) begin
                    state_d               = ST_GAP;
                    snooze_req[ring_ch_q] = 1'b1;
                end
                if (state_d == ST_GAP) gap_cnt_d = '0;
            end
            ST_GAP: begin
                if (gap_cnt_q >= GAP_W'(GAP_MS - 1)) state_d = ST_IDLE;
                else gap_cnt_d = gap_cnt_q + GAP_W'(1);
            end
            default: state_d = ST_IDLE;
        endcase

        if (!ring_en) state_d = ST_IDLE;
    end

    always_ff @(posedge clk_01 or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            ring_ch_q   <= '0;
            gap_cnt_q   <= '0;
            tmo_q       <= '0;
            beep_cnt_q  <= '0;
            beep_ph_q   <= 1'b0;
            stop_prev_q <= 1'b0;
            snz_prev_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ring_ch_q   <= ring_ch_d;
            gap_cnt_q   <= gap_cnt_d;
            tmo_q       <= tmo_d;
            beep_cnt_q  <= beep_cnt_d;
            beep_ph_q   <= beep_ph_d;
            stop_prev_q <= stop_btn;
            snz_prev_q  <= snooze_btn;
        end
    end

    // Gated by ring_en so dropping it silences outputs immediately.
    assign ring_active = ring_en && (state_q == ST_RING);
    assign ring_id     = ring_active ? ring_ch_q : '0;
    assign buzz        = ring_active && (!pulse_mode || beep_ph_q);
    assign led         = buzz ? (NUM_CH'(1) << ring_ch_q) : '0;

endmodule

// File: tb/tb_alarm_scheduler.sv
// Scenario bench for alarm_scheduler: each task queues expected output words,
// records the observed words and compares them in order.
module tb_alarm_scheduler;

    logic       clk_01 = 1'b0;
    logic       rst, tick_1hz, ring_en, pulse_mode, snooze_btn, stop_btn;
    logic [3:0] match, arm;
    logic       ring_active, buzz;
    logic [1:0] ring_id;
    logic [3:0] led, snoozed;

    int checks = 0;
    int errors = 0;

    // Word layout: {ring_active, ring_id[1:0], led[3:0], buzz, snoozed[3:0]}
    typedef struct {
        string      tag;
        logic [11:0] val;
    } item_t;
    item_t exp_q[$];
    item_t obs_q[$];

    alarm_scheduler #(
        .SNOOZE_S   (5),
        .TIMEOUT_S  (60),
        .MAX_SNOOZE (3),
        .GAP_MS     (100),
        .BEEP_MS    (100)
    ) dut (
        .clk_01      (clk_01),
        .rst         (rst),
        .tick_1hz    (tick_1hz),
        .match       (match),
        .arm         (arm),
        .ring_en     (ring_en),
        .pulse_mode  (pulse_mode),
        .snooze_btn  (snooze_btn),
        .stop_btn    (stop_btn),
        .ring_active (ring_active),
        .ring_id     (ring_id),
        .led         (led),
        .buzz        (buzz),
        .snoozed     (snoozed)
    );

    always #5 clk_01 = ~clk_01;

    task automatic observe(input string tag);
        obs_q.push_back('{tag, {ring_active, ring_id, led, buzz, snoozed}});
    endtask

    task automatic expect_word(input string tag, input logic [11:0] v);
        exp_q.push_back('{tag, v});
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk_01);
    endtask

    task automatic tick();
        tick_1hz = 1'b1;
        @(negedge clk_01);
        tick_1hz = 1'b0;
        @(negedge clk_01);
    endtask

    task automatic quiesce();
        match = '0; stop_btn = 1'b0; snooze_btn = 1'b0; tick_1hz = 1'b0;
        pulse_mode = 1'b0; ring_en = 1'b1;
        arm = 4'h0;
        cyc(2);
        arm = 4'hF;
        cyc(110);
    endtask

    task automatic test_reset();
        item_t e, o;
        rst = 1'b0; tick_1hz = 1'b0; match = '0; arm = 4'hF; ring_en = 1'b1;
        pulse_mode = 1'b0; snooze_btn = 1'b0; stop_btn = 1'b0;
        cyc(3);
        expect_word("reset_outputs", 12'h000);
        observe("reset_outputs");
        rst = 1'b1;
        cyc(3);
        expect_word("after_release_idle", 12'h000);
        observe("after_release_idle");
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++; $display("FAIL %s: no output observed, required %h", e.tag, e.val);
            end else begin
                o = obs_q.pop_front();
                if (o.val !== e.val) begin
                    errors++; $display("FAIL %s: got %h required %h", e.tag, o.val, e.val);
                end
            end
        end
    endtask

    task automatic test_timeout_snooze();
        item_t e, o;
        match = 4'b0100;
        expect_word("ch2_rings", {1'b1, 2'd2, 4'b0100, 1'b1, 4'b0000});
        cyc(2);
        observe("ch2_rings");
        for (int i = 0; i < 59; i++) tick();
        expect_word("ch2_still_ringing_59", {1'b1, 2'd2, 4'b0100, 1'b1, 4'b0000});
        observe("ch2_still_ringing_59");
        tick();
        expect_word("ch2_auto_snoozed", {1'b0, 2'd0, 4'b0000, 1'b0, 4'b0100});
        observe("ch2_auto_snoozed");
        quiesce();
        expect_word("ch2_quiesced", 12'h000);
        observe("ch2_quiesced");
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++; $display("FAIL %s: no output observed, required %h", e.tag, e.val);
            end else begin
                o = obs_q.pop_front();
                if (o.val !== e.val) begin
                    errors++; $display("FAIL %s: got %h required %h", e.tag, o.val, e.val);
                end
            end
        end
    endtask

    task automatic test_priority_gap();
        item_t e, o;
        match = 4'b1010;
        expect_word("prio_ch1_first", {1'b1, 2'd1, 4'b0010, 1'b1, 4'b0000});
        cyc(2);
        observe("prio_ch1_first");
        stop_btn = 1'b1;
        expect_word("gap_entered", 12'h000);
        cyc(1);
        stop_btn = 1'b0;
        observe("gap_entered");
        cyc(100);
        expect_word("gap_last_silent", 12'h000);
        observe("gap_last_silent");
        cyc(1);
        expect_word("ch3_after_gap", {1'b1, 2'd3, 4'b1000, 1'b1, 4'b0000});
        observe("ch3_after_gap");
        quiesce();
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++; $display("FAIL %s: no output observed, required %h", e.tag, e.val);
            end else begin
                o = obs_q.pop_front();
                if (o.val !== e.val) begin
                    errors++; $display("FAIL %s: got %h required %h", e.tag, o.val, e.val);
                end
            end
        end
    endtask

    task automatic test_snooze_limit();
        item_t e, o;
        match = 4'b0001;
        expect_word("ch0_rings", {1'b1, 2'd0, 4'b0001, 1'b1, 4'b0000});
        cyc(2);
        observe("ch0_rings");
        for (int k = 0; k < 3; k++) begin
            snooze_btn = 1'b1;
            cyc(1);
            snooze_btn = 1'b0;
            cyc(105);
            for (int t = 0; t < 4; t++) tick();
            expect_word($sformatf("snoozed_wait_%0d", k), {1'b0, 2'd0, 4'b0000, 1'b0, 4'b0001});
            observe($sformatf("snoozed_wait_%0d", k));
            tick();
            expect_word($sformatf("rering_%0d", k), {1'b1, 2'd0, 4'b0001, 1'b1, 4'b0000});
            observe($sformatf("rering_%0d", k));
        end
        snooze_btn = 1'b1;
        cyc(1);
        snooze_btn = 1'b0;
        expect_word("fourth_snooze_dismiss", 12'h000);
        observe("fourth_snooze_dismiss");
        cyc(110);
        for (int t = 0; t < 6; t++) tick();
        expect_word("stays_dismissed", 12'h000);
        observe("stays_dismissed");
        quiesce();
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++; $display("FAIL %s: no output observed, required %h", e.tag, e.val);
            end else begin
                o = obs_q.pop_front();
                if (o.val !== e.val) begin
                    errors++; $display("FAIL %s: got %h required %h", e.tag, o.val, e.val);
                end
            end
        end
    endtask

    task automatic test_pulse_and_both_buttons();
        item_t e, o;
        logic  bz;
        pulse_mode = 1'b1;
        match = 4'b0010;
        cyc(2);
        for (int j = 0; j < 300; j++) begin
            bz = ((j / 100) % 2) == 0;
            expect_word($sformatf("beep_%0d", j), {1'b1, 2'd1, bz ? 4'b0010 : 4'b0000, bz, 4'b0000});
            observe($sformatf("beep_%0d", j));
            cyc(1);
        end
        stop_btn = 1'b1;
        snooze_btn = 1'b1;
        cyc(1);
        stop_btn = 1'b0;
        snooze_btn = 1'b0;
        expect_word("stop_and_snooze_is_stop", 12'h000);
        observe("stop_and_snooze_is_stop");
        cyc(110);
        for (int t = 0; t < 6; t++) tick();
        expect_word("no_snooze_rering", 12'h000);
        observe("no_snooze_rering");
        quiesce();
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++; $display("FAIL %s: no output observed, required %h", e.tag, e.val);
            end else begin
                o = obs_q.pop_front();
                if (o.val !== e.val) begin
                    errors++; $display("FAIL %s: got %h required %h", e.tag, o.val, e.val);
                end
            end
        end
    endtask

    task automatic test_ring_en_reset_disarm();
        item_t e, o;
        match = 4'b0011;
        expect_word("en_ch0_rings", {1'b1, 2'd0, 4'b0001, 1'b1, 4'b0000});
        cyc(2);
        observe("en_ch0_rings");
        ring_en = 1'b0;
        expect_word("ring_en_low_silent", 12'h000);
        cyc(1);
        observe("ring_en_low_silent");
        ring_en = 1'b1;
        cyc(5);
        expect_word("pending_cleared", 12'h000);
        observe("pending_cleared");
        quiesce();
        match = 4'b1000;
        expect_word("rst_ch3_rings", {1'b1, 2'd3, 4'b1000, 1'b1, 4'b0000});
        cyc(2);
        observe("rst_ch3_rings");
        rst = 1'b0;
        #1;
        expect_word("async_reset_silent", 12'h000);
        observe("async_reset_silent");
        cyc(1);
        rst = 1'b1;
        cyc(2);
        expect_word("retrigger_after_reset", {1'b1, 2'd3, 4'b1000, 1'b1, 4'b0000});
        observe("retrigger_after_reset");
        arm = 4'b0111;
        cyc(1);
        expect_word("disarm_ends_ring", 12'h000);
        observe("disarm_ends_ring");
        quiesce();
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++; $display("FAIL %s: no output observed, required %h", e.tag, e.val);
            end else begin
                o = obs_q.pop_front();
                if (o.val !== e.val) begin
                    errors++; $display("FAIL %s: got %h required %h", e.tag, o.val, e.val);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_timeout_snooze();
        test_priority_gap();
        test_snooze_limit();
        test_pulse_and_both_buttons();
        test_ring_en_reset_disarm();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alarm_scheduler.md
ALARM_SCHEDULER -- requirements
Module: alarm_scheduler

Interface
REQ-001 SHALL have parameters: SNOOZE_S, default 300, snooze length in seconds; TIMEOUT_S, default 60, unattended ring limit in seconds; MAX_SNOOZE, default 3, snoozes allowed per trigger; GAP_MS, default 100, silent gap between rings in cycles; BEEP_MS, default 100, pulse-mode half-period in cycles.
REQ-002 SHALL use reset rst, asynchronous, active-low; clock clk_01.
REQ-003 clk_01  in  1  1 kHz system clock.
REQ-004 rst  in  1  async active-low reset.
REQ-005 tick_1hz  in  1  one-cycle pulse in clk_01 domain, once per second.
REQ-006 match  in  4  per-alarm level: current time equals alarm time.
REQ-007 arm  in  4  per-alarm enable.
REQ-008 ring_en  in  1  global ringing enable.
REQ-009 pulse_mode  in  1  1 = beeping output, 0 = steady output.
REQ-010 snooze_btn, stop_btn  in  1 each  synchronous level buttons, active-high.
REQ-011 ring_active  out  1  a channel is ringing.
REQ-012 ring_id  out  2  index of ringing channel, 0 when idle.
REQ-013 led  out  4  one-hot ringing channel AND buzz, else 0.
REQ-014 buzz  out  1  audible drive.
REQ-015 snoozed  out  4  per-channel snooze-timer-running flags.

Function
REQ-016 Channel trigger SHALL be the rising edge of (match[i] & arm[i]), sampled each clk_01 cycle; it sets pending[i] and loads snooze_cnt[i] = 0.
REQ-017 Trigger on a channel already pending, ringing or snoozed SHALL be ignored.
REQ-018 Deasserting arm[i] SHALL clear pending[i], snooze state and, if ringing, end the ring (go to GAP) the next cycle.
REQ-019 FSM states IDLE, RING, GAP; IDLE->RING when any pending and ring_en; RING->GAP on stop, snooze, timeout or disarm; GAP->IDLE after GAP_MS cycles.
REQ-020 Arbitration SHALL be fixed priority, lowest index first, among pending channels; a ringing channel SHALL NOT be pre-empted.
REQ-021 Entering RING SHALL clear pending of the granted channel; ring_active, ring_id valid in the cycle after the grant.
REQ-022 stop_btn rising edge in RING SHALL dismiss the channel (no pending, no snooze).
REQ-023 snooze_btn rising edge in RING SHALL, if snooze_cnt < MAX_SNOOZE, increment snooze_cnt and start a SNOOZE_S-second countdown; else dismiss.
REQ-024 Simultaneous stop and snooze edges SHALL act as stop.
REQ-025 TIMEOUT_S tick_1hz pulses in RING with no button SHALL behave as a snooze edge.
REQ-026 Snooze countdown SHALL decrement on tick_1hz; at zero it SHALL set pending[i] and clear snoozed[i]; if another channel rings, it waits.
REQ-027 buzz SHALL be 1 throughout RING when pulse_mode=0; when pulse_mode=1, toggle every BEEP_MS cycles starting at 1 on RING entry; 0 outside RING.
REQ-028 ring_en low SHALL force IDLE within one cycle, clear all pending, keep snooze timers running, and drive buzz, led, ring_active to 0.
REQ-029 Second/timeout counters SHALL saturate, never wrap; snooze_cnt width SHALL hold MAX_SNOOZE.

Reset
REQ-030 On rst low: state IDLE, pending, snoozed, snooze_cnt, all timers and edge registers 0; ring_active 0, ring_id 0, led 0, buzz 0.
REQ-031 Reset mid-ring SHALL silence outputs asynchronously; edge registers reset to 0, so a match held high across reset retriggers once after release only if armed.

Structure
REQ-032 Package alarm_pkg SHALL hold FSM state encoding, channel count 4, and the default parameter values.
REQ-033 Per-channel logic (edge detect, pending, snooze countdown, snooze_cnt) SHALL be sub-module alarm_chan, instantiated 4 times; FSM, arbiter, beep timer in the top.

Verification
REQ-034 arm=1111, match[2] rises, no buttons -> ring_id=2, led=0100 within 2 cycles; after 60 ticks auto-snooze, snoozed[2]=1.
REQ-035 match[1] and match[3] rise same cycle -> channel 1 rings; stop -> 100-cycle GAP -> channel 3 rings.
REQ-036 Channel 0 ringing, snooze 3 times with SNOOZE_S=5 -> rings again after 5 ticks each time; 4th snooze dismisses, snoozed[0]=0.
REQ-037 pulse_mode=1 in RING -> buzz 1 for 100 cycles, 0 for 100, repeating; stop and snooze same cycle -> dismissed, no snooze.
REQ-038 ring_en dropped during RING with channel 2 pending -> IDLE, outputs 0, pending cleared next cycle; rst low mid-ring -> all outputs 0 immediately.
